gpioemu_host: RTL

Bus initiator for the SYKT GPIO multiplier peripheral: it drives the peripheral's `saddress`/`srd`/`swr`/`sdata_in` strobes and reads back its `sdata_out`. It accepts an operand pair on a valid/ready command port and writes A1 and A2. It then polls the status register B until the peripheral reports finish or malformed input. On finish it reads product W and ones-count L and returns everything on a valid/ready response port. It sits between a test/CPU-side sequencer and the peripheral, in place of the kernel driver.

---
 rtl/gpioemu_host_if.sv | 38 +++
 rtl/gpioemu_host.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_host_if.sv
// gpioemu_host_if
//
// Register-bus connection between the gpioemu_host initiator and the SYKT
// GPIO multiplier peripheral.
//
// Signals:
//   saddress  [31:0]  register offset driven by the initiator
//   srd               read strobe (initiator -> peripheral)
//   swr               write strobe (initiator -> peripheral)
//   sdata_in  [31:0]  write data (initiator -> peripheral)
//   sdata_out [31:0]  read data (peripheral -> initiator)
//
// Modports:
//   master  the initiator side (gpioemu_host)
//   slave   the peripheral side
interface gpioemu_host_if;
  logic [31:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (
    output saddress,
    output srd,
    output swr,
    output sdata_in,
    input  sdata_out
  );

  modport slave (
    input  saddress,
    input  srd,
    input  swr,
    input  sdata_in,
    output sdata_out
  );
endinterface

// File: rtl/gpioemu_host.sv
// gpioemu_host
//
// Bus initiator for the SYKT GPIO multiplier peripheral. Takes an operand
// pair on a valid/ready command port, writes A1 and A2, polls status register
// B until the peripheral reports finish or malformed input (or the poll budget
// runs out), then on finish reads product W and ones-count L. The outcome is
// returned on a valid/ready response port.
//
// Every bus access is SETUP (1 cycle) + STROBE (STROBE_CYCLES cycles) +
// HOLD (1 cycle). Read data is captured on the edge that ends the last
// STROBE cycle.
//
// Ports:
//   clk          single clock, rising edge
//   n_reset      asynchronous active-low reset
//   cmd_valid    operand pair offered
//   cmd_ready    high only in IDLE (and out of reset)
//   cmd_a1/a2    operands
//   rsp_valid    response valid, held until accepted
//   rsp_ready    response consumer ready
//   rsp_product  W value read
//   rsp_ones     L value read
//   rsp_flags    last B value read
//   rsp_status   0 OK, 1 overflow, 2 malformed, 3 timeout
//   bus          peripheral register bus (master modport)
module gpioemu_host #(
  parameter int          STROBE_CYCLES = 2,
  parameter int          POLL_LIMIT    = 64,
  parameter logic [31:0] MAX_INPUT     = 32'hFFFFFF,
  parameter logic [31:0] ADDR_A1       = 32'h2C8,
  parameter logic [31:0] ADDR_A2       = 32'h2D0,
  parameter logic [31:0] ADDR_W        = 32'h2D8,
  parameter logic [31:0] ADDR_L        = 32'h2E0,
  parameter logic [31:0] ADDR_B        = 32'h2E8
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a1,
  input  logic [31:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_product,
  output logic [31:0] rsp_ones,
  output logic [7:0]  rsp_flags,
  output logic [1:0]  rsp_status,
  gpioemu_host_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_A1,
    WR_A2,
    POLL_B,
    RD_W,
    RD_L,
    RESP
  } state_t;

  localparam logic [31:0] STROBE_LAST = 32'(STROBE_CYCLES);
  localparam logic [31:0] HOLD_PHASE  = 32'(STROBE_CYCLES + 1);
  localparam logic [31:0] POLL_MAX    = 32'(POLL_LIMIT);

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_MALFORMED = 2'd2;
  localparam logic [1:0] ST_TIMEOUT   = 2'd3;

  state_t      state;
  state_t      state_next;
  logic [31:0] phase;
  logic [31:0] phase_next;

  logic [31:0] a1;
  logic [31:0] a2;
  logic [31:0] poll_cnt;
  logic [31:0] poll_inc;
  logic [31:0] product;
  logic [31:0] ones;
  logic [7:0]  flags;
  logic [1:0]  status;

  logic        in_access;
  logic        is_write;
  logic        is_read;
  logic [31:0] addr_sel;
  logic [31:0] wdata;
  logic        cmd_fire;
  logic        cmd_bad;
  logic        access_end;
  logic        strobe_on;
  logic        capture;

  // phase counts 0 (SETUP), 1..STROBE_CYCLES (STROBE), STROBE_CYCLES+1 (HOLD);
  // it is parked at 0 whenever no access is running.
  assign access_end = (phase == HOLD_PHASE);
  assign strobe_on  = (phase != 32'd0) && (phase <= STROBE_LAST);
  assign capture    = is_read && (phase == STROBE_LAST);
  assign poll_inc   = poll_cnt + 32'd1;
  assign cmd_bad    = (cmd_a1 > MAX_INPUT) || (cmd_a2 > MAX_INPUT);

  // Bus outputs are decoded from registered state so an asynchronous reset
  // drops the strobes in the same cycle it is asserted.
  assign bus.saddress = addr_sel;
  assign bus.sdata_in = wdata;
  assign bus.swr      = is_write && strobe_on;
  assign bus.srd      = is_read && strobe_on;

  // cmd_ready is masked by reset so that every output reads 0 while reset is
  // held, and rises as soon as reset is released.
  assign cmd_ready   = (state == IDLE) && n_reset;
  assign rsp_valid   = (state == RESP);
  assign rsp_product = product;
  assign rsp_ones    = ones;
  assign rsp_flags   = flags;
  assign rsp_status  = status;

  // State register: FSM state plus the position inside the current access.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // Next-state and access decode. Each bus state runs one full access and
  // only moves on at the end of its HOLD cycle, which keeps accesses
  // back-to-back. The B decision uses the value captured during the strobe.
  always_comb begin
    state_next = state;
    phase_next = phase;
    in_access  = 1'b0;
    is_write   = 1'b0;
    is_read    = 1'b0;
    addr_sel   = '0;
    wdata      = '0;
    cmd_fire   = 1'b0;

    case (state)
      IDLE: begin
        cmd_fire = cmd_valid;
        if (cmd_valid) begin
          state_next = cmd_bad ? RESP : WR_A1;
        end
      end
      WR_A1: begin
        in_access = 1'b1;
        is_write  = 1'b1;
        addr_sel  = ADDR_A1;
        wdata     = a1;
        if (access_end) state_next = WR_A2;
      end
      WR_A2: begin
        in_access = 1'b1;
        is_write  = 1'b1;
        addr_sel  = ADDR_A2;
        wdata     = a2;
        if (access_end) state_next = POLL_B;
      end
      POLL_B: begin
        in_access = 1'b1;
        is_read   = 1'b1;
        addr_sel  = ADDR_B;
        if (access_end) begin
          if (flags[4]) begin
            state_next = RD_W;
          end else if (flags[2] || flags[3]) begin
            state_next = RESP;
          end else if (poll_inc == POLL_MAX) begin
            state_next = RESP;
          end else begin
            state_next = POLL_B;
          end
        end
      end
      RD_W: begin
        in_access = 1'b1;
        is_read   = 1'b1;
        addr_sel  = ADDR_W;
        if (access_end) state_next = RD_L;
      end
      RD_L: begin
        in_access = 1'b1;
        is_read   = 1'b1;
        addr_sel  = ADDR_L;
        if (access_end) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (in_access) begin
      phase_next = access_end ? 32'd0 : phase + 32'd1;
    end
  end

  // Datapath: operand latches, poll counter and the response registers.
  // Response fields are cleared when a command is taken, so a locally
  // rejected or timed-out command reports zeros for values never read.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1       <= '0;
      a2       <= '0;
      poll_cnt <= '0;
      product  <= '0;
      ones     <= '0;
      flags    <= '0;
      status   <= ST_OK;
    end else begin
      if (cmd_fire) begin
        a1      <= cmd_a1;
        a2      <= cmd_a2;
        product <= '0;
        ones    <= '0;
        flags   <= '0;
        status  <= cmd_bad ? ST_MALFORMED : ST_OK;
      end

      if (state == WR_A2) begin
        poll_cnt <= '0;
      end

      if (capture) begin
        case (state)
          POLL_B:  flags   <= bus.sdata_out[7:0];
          RD_W:    product <= bus.sdata_out;
          RD_L:    ones    <= bus.sdata_out;
          default: ;
        endcase
      end

      // Status is settled at the end of the B read that ends polling; on the
      // finish path bit 0 of that B value marks overflow.
      if ((state == POLL_B) && access_end) begin
        poll_cnt <= poll_inc;
        if (flags[4]) begin
          status <= {1'b0, flags[0]};
        end else if (flags[2] || flags[3]) begin
          status <= ST_MALFORMED;
        end else if (poll_inc == POLL_MAX) begin
          status <= ST_TIMEOUT;
        end
      end
    end
  end

endmodule
